// File: rtl/sram_sp_ctrl_if.sv
// Request/response handshake bundle between a requester and sram_sp_ctrl.
// master = requester side, slave = controller side.
interface sram_sp_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM request controller; macro pins driven in the accept cycle, Q captured into a 2-entry response FIFO.
// Latency: read accepted in cycle N gives resp_valid from N+2. Reads are credit-gated on FIFO space, writes only on RUN.
// Optional SRAM_CLEAR_EN: zero-fill all DEPTH words after reset before accepting requests.
module sram_sp_ctrl #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 7,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    sram_sp_ctrl_if.slave     bus,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

`ifdef SRAM_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];

    logic       run;
    logic       fire;
    logic       pop;
    logic       push;
    logic       credit_ok;
    logic [2:0] occupancy;

    assign run        = ~reset & (state_q == ST_RUN);
    assign pop        = bus.resp_valid & bus.resp_ready;
    assign push       = rd_pend_q;

    // Slots already claimed (stored + in flight from the macro), less the one leaving this cycle.
    assign occupancy  = {1'b0, count_q} + {2'b0, rd_pend_q} - {2'b0, pop};
    assign credit_ok  = occupancy < 3'(RESP_DEPTH);

    assign bus.req_ready  = run & (bus.req_write | credit_ok);
    assign fire           = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = (count_q != 2'd0);
    assign bus.resp_rdata = fifo_q[rd_ptr_q];

    assign rd_pend_d = fire & ~bus.req_write;
    assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        sram_ceb   = 1'b1;
        sram_web   = 1'b1;
        sram_a     = '0;
        sram_d     = '0;
        case (state_q)
            ST_CLEAR: begin
                if (!reset) begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = clr_addr_q;
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        clr_addr_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (fire) begin
                    sram_ceb = 1'b0;
                    sram_web = ~bus.req_write;
                    sram_a   = bus.req_addr;
                    sram_d   = bus.req_wdata;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_pend_q  <= rd_pend_d;
            count_q    <= count_d;
            // Q is only meaningful the cycle after a read; never sample it otherwise.
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed + random bench for sram_sp_ctrl with a behavioural SRAM macro and an
// outstanding-read queue reference model.
module tb_sram_sp_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_sp_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    sram_sp_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESP_DEPTH(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .sram_ceb (sram_ceb),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    // Macro behaviour: Q is valid only the cycle after a read; garbage otherwise.
    logic [DATA_W-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (!sram_ceb && !sram_web) macro_mem[sram_a] <= sram_d;
        if (!sram_ceb && sram_web) sram_q <= macro_mem[sram_a];
        else                       sram_q <= $urandom;
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    int                vectors     = 0;
    int                miscompares = 0;
    int                cyc         = 0;
    int                clear_left  = 0;
    int                resp_seen   = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    resp_t             exp_q [$];
    bit                last_valid;
    logic [DATA_W-1:0] last_rdata;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(output bit fired);
        bit exp_valid, exp_ready, pop, in_clear;
        logic [ADDR_W-1:0] ea;
        @(negedge clock);
        in_clear  = (clear_left > 0);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        pop       = exp_valid && bus.resp_ready;
        exp_ready = !in_clear && (bus.req_write || ((exp_q.size() - int'(pop)) < 2));
        fired     = bus.req_valid && exp_ready;
        last_valid = bus.resp_valid;
        last_rdata = bus.resp_rdata;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
        if (exp_valid) check("resp_rdata", bus.resp_rdata, exp_q[0].data);
        ea = ADDR_W'(DEPTH - clear_left);
        if (in_clear) begin
            check("clr_ceb", 32'(sram_ceb), 32'd0);
            check("clr_web", 32'(sram_web), 32'd0);
            check("clr_a", 32'(sram_a), 32'(ea));
            check("clr_d", sram_d, 32'd0);
        end else if (fired) begin
            check("acc_ceb", 32'(sram_ceb), 32'd0);
            check("acc_web", 32'(sram_web), 32'(!bus.req_write));
            check("acc_a", 32'(sram_a), 32'(bus.req_addr));
            if (bus.req_write) check("acc_d", sram_d, bus.req_wdata);
        end else begin
            check("idle_pins", {sram_ceb, sram_web, 23'(sram_a), sram_d[6:0]},
                  {1'b1, 1'b1, 23'd0, 7'd0});
            check("idle_d", sram_d, 32'd0);
        end
        @(posedge clock);
        if (in_clear) begin
            ref_mem[ea] = '0;
            clear_left--;
        end else if (fired) begin
            if (bus.req_write) ref_mem[bus.req_addr] = bus.req_wdata;
            else exp_q.push_back('{data: ref_mem[bus.req_addr], due: cyc + 2});
        end
        if (pop) begin
            void'(exp_q.pop_front());
            resp_seen++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit f;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        repeat (n) step(f);
    endtask

    task automatic send(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output int tries);
        bit f;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tries = 0;
        f = 1'b0;
        while (!f && tries < 50) begin
            step(f);
            tries++;
        end
        if (!f) check("send_timeout", 32'(tries), 32'd0);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
    endtask

    task automatic do_reset(input int n);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        reset = 1'b1;
        repeat (n) begin
            @(negedge clock);
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_pins", {30'd0, sram_ceb, sram_web}, 32'd3);
            check("rst_a", 32'(sram_a), 32'd0);
            @(posedge clock);
            cyc++;
        end
        #1;
        reset = 1'b0;
        exp_q.delete();
`ifdef SRAM_CLEAR_EN
        clear_left = DEPTH;
`else
        clear_left = 0;
`endif
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    endtask

    initial begin
        int t;
        bit f;
        int seen0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            macro_mem[i] = $urandom;
            ref_mem[i]   = macro_mem[i];
        end

        do_reset(3);
`ifdef SRAM_CLEAR_EN
        idle(DEPTH / 2);
        do_reset(1);
        idle(DEPTH);
        bus.resp_ready = 1'b1;
        send(1'b0, 7'h7F, 32'd0, t);
        idle(2);
        check("clr_read_7f", last_rdata, 32'd0);
        check("clr_read_vld", 32'(last_valid), 32'd1);
`else
        bus.resp_ready = 1'b1;
        send(1'b1, 7'h00, 32'h0, t);
        check("first_write_tries", 32'(t), 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) send(1'b1, ADDR_W'(i), $urandom, t);

        // write then read of the same address, back to back
        bus.resp_ready = 1'b1;
        send(1'b1, 7'h05, 32'hDEADBEEF, t);
        send(1'b0, 7'h05, 32'h0, t);
        check("raw_tries", 32'(t), 32'd1);
        idle(1);
        check("raw_lat_n1", 32'(last_valid), 32'd0);
        idle(1);
        check("raw_lat_n2", 32'(last_valid), 32'd1);
        check("raw_data", last_rdata, 32'hDEADBEEF);

        // credit backpressure
        for (int i = 0; i < 4; i++) send(1'b1, ADDR_W'(i), 32'h10 + 32'(i), t);
        bus.resp_ready = 1'b0;
        seen0 = resp_seen;
        send(1'b0, 7'h00, 32'h0, t);
        send(1'b0, 7'h01, 32'h0, t);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 7'h02;
        repeat (4) begin
            step(f);
            check("bp_blocked", 32'(f), 32'd0);
        end
        bus.resp_ready = 1'b1;
        send(1'b0, 7'h02, 32'h0, t);
        send(1'b0, 7'h03, 32'h0, t);
        idle(4);
        check("bp_all_delivered", 32'(resp_seen - seen0), 32'd4);

        // streaming alternating write/read, full throughput
        for (int i = 0; i < 100; i++) begin
            send(i[0], ADDR_W'($urandom_range(0, 7)), $urandom, t);
            if (t != 1) check("stream_throughput", 32'(t), 32'd1);
        end
        idle(3);

        // reset one cycle after a read accept
        seen0 = resp_seen;
        send(1'b0, 7'h05, 32'h0, t);
        do_reset(2);
`ifdef SRAM_CLEAR_EN
        idle(DEPTH);
`endif
        idle(5);
        check("rst_no_resp", 32'(resp_seen - seen0), 32'd0);
        send(1'b0, 7'h06, 32'h0, t);
        idle(3);

        // idle garbage on Q while a response is parked
        bus.resp_ready = 1'b0;
        send(1'b0, 7'h01, 32'h0, t);
        idle(8);
        check("park_valid", 32'(last_valid), 32'd1);
        check("park_data", last_rdata, ref_mem[1]);
        bus.resp_ready = 1'b1;
        idle(2);
        check("park_drained", 32'(last_valid), 32'd0);

        // random mix with random backpressure
        for (int i = 0; i < 300; i++) begin
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_addr   = ADDR_W'($urandom_range(0, 15));
            bus.req_wdata  = $urandom;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            step(f);
        end
        bus.resp_ready = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
